single_integer_part_arbiter: RTL and testbench

//  Shares one single-precision integer-part (truncate-toward-zero) unit among N requesters.

---
 rtl/single_integer_part_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_single_integer_part_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/single_integer_part_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : single_integer_part_arbiter
// Description : Round-robin arbiter that shares one integer-part (truncate
//               toward zero) unit among N_REQ requesters. Each issue carries
//               its requester tag, and the returned result goes back to that
//               requester. The optional sticky protocol error is built when
//               SINGLE_INT_ARB_ERR_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module single_integer_part_arbiter #(
    parameter int N_REQ        = 4,
    parameter int UNIT_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [32*N_REQ-1:0]   req_a,
    output logic [N_REQ-1:0]      resp_valid,
    input  logic [N_REQ-1:0]      resp_ready,
    output logic [32*N_REQ-1:0]   resp_c,
    output logic                  unit_in_valid,
    output logic [31:0]           unit_a,
    input  logic                  unit_out_valid,
    input  logic [31:0]           unit_c,
    output logic                  err
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int DEPTH = UNIT_LATENCY + 1;

    logic [N_REQ-1:0] w_pending;
    logic [N_REQ-1:0] w_elig;
    logic             w_hi_vld;
    logic             w_lo_vld;
    logic [IDX_W-1:0] w_hi_idx;
    logic [IDX_W-1:0] w_lo_idx;
    logic             w_gnt_vld;
    logic [IDX_W-1:0] w_gnt_idx;
    logic [IDX_W-1:0] w_rr_next;
    logic [31:0]      w_gnt_a;
    logic [IDX_W-1:0] r_rr_ptr;
    logic             r_tag_vld [DEPTH];
    logic [IDX_W-1:0] r_tag_idx [DEPTH];
    logic             w_ret_vld;
    logic [IDX_W-1:0] w_ret_idx;

    assign w_elig    = req_valid & ~w_pending;
    assign w_ret_vld = r_tag_vld[UNIT_LATENCY];
    assign w_ret_idx = r_tag_idx[UNIT_LATENCY];

    // Lowest eligible index at or above the pointer wins; otherwise wrap to the lowest overall.
    always_comb begin
        w_hi_vld = 1'b0;
        w_hi_idx = '0;
        w_lo_vld = 1'b0;
        w_lo_idx = '0;
        for (int p = N_REQ - 1; p >= 0; p--) begin
            if (w_elig[p]) begin
                w_lo_vld = 1'b1;
                w_lo_idx = IDX_W'(p);
                if (IDX_W'(p) >= r_rr_ptr) begin
                    w_hi_vld = 1'b1;
                    w_hi_idx = IDX_W'(p);
                end
            end
        end
        w_gnt_vld = w_lo_vld && !rst;
        w_gnt_idx = w_hi_vld ? w_hi_idx : w_lo_idx;
    end

    always_comb begin
        req_ready = '0;
        w_gnt_a   = '0;
        for (int p = 0; p < N_REQ; p++) begin
            if (w_gnt_idx == IDX_W'(p)) begin
                req_ready[p] = w_gnt_vld;
                w_gnt_a      = req_a[32*p +: 32];
            end
        end
    end

    assign w_rr_next = (w_gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : w_gnt_idx + IDX_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            unit_in_valid <= 1'b0;
            unit_a        <= '0;
            r_rr_ptr      <= '0;
        end else begin
            unit_in_valid <= w_gnt_vld;
            if (w_gnt_vld) begin
                unit_a   <= w_gnt_a;
                r_rr_ptr <= w_rr_next;
            end
        end
    end

    // Stage UNIT_LATENCY lines up with unit_out_valid for the same operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int d = 0; d < DEPTH; d++) begin
                r_tag_vld[d] <= 1'b0;
                r_tag_idx[d] <= '0;
            end
        end else begin
            r_tag_vld[0] <= w_gnt_vld;
            r_tag_idx[0] <= w_gnt_idx;
            for (int d = 1; d < DEPTH; d++) begin
                r_tag_vld[d] <= r_tag_vld[d-1];
                r_tag_idx[d] <= r_tag_idx[d-1];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_port
            logic        r_pend;
            logic        r_rvld;
            logic [31:0] r_c;
            logic        w_tag_hit;
            logic        w_ret_hit;
            logic        w_orphan;
            logic        w_drain;

            assign w_tag_hit = w_ret_vld && (w_ret_idx == IDX_W'(gi));
            assign w_ret_hit = w_tag_hit && unit_out_valid;
            assign w_orphan  = w_tag_hit && !unit_out_valid;
            assign w_drain   = r_rvld && resp_ready[gi];

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_pend <= 1'b0;
                    r_rvld <= 1'b0;
                    r_c    <= '0;
                end else begin
                    if (w_ret_hit) begin
                        r_rvld <= 1'b1;
                        r_c    <= unit_c;
                    end else if (w_drain) begin
                        r_rvld <= 1'b0;
                    end
                    // A lost result frees the port so it cannot stall forever.
                    if (req_ready[gi]) begin
                        r_pend <= 1'b1;
                    end else if (w_drain || w_orphan) begin
                        r_pend <= 1'b0;
                    end
                end
            end

            assign w_pending[gi]        = r_pend;
            assign resp_valid[gi]       = r_rvld;
            assign resp_c[32*gi +: 32]  = r_c;
        end
    endgenerate

`ifdef SINGLE_INT_ARB_ERR_EN
    localparam int MASK_W = $clog2(DEPTH + 1);

    logic [MASK_W-1:0] r_mask_cnt;
    logic              r_err;

    // Results already in flight when reset hit must not count as errors.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mask_cnt <= MASK_W'(DEPTH);
            r_err      <= 1'b0;
        end else if (r_mask_cnt != '0) begin
            r_mask_cnt <= r_mask_cnt - MASK_W'(1);
        end else if (unit_out_valid != w_ret_vld) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_single_integer_part_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_single_integer_part_arbiter
// Description : Scoreboard bench for single_integer_part_arbiter with a
//               behavioural truncation unit and a round-robin reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_single_integer_part_arbiter;

    localparam int N = 4;
    localparam int L = 1;

    typedef struct {
        logic [31:0] c;
        int          due;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [32*N-1:0] req_a;
    logic [N-1:0]    resp_valid;
    logic [N-1:0]    resp_ready;
    logic [32*N-1:0] resp_c;
    logic            unit_in_valid;
    logic [31:0]     unit_a;
    logic            unit_out_valid;
    logic [31:0]     unit_c;
    logic            err;

    exp_t     sb [N][$];
    exp_t     upipe [$];
    int       cyc = 0;
    int       n_cmp = 0;
    int       n_fail = 0;
    int       err_set_cyc = -1;
    int       rr_m = 0;
    logic [N-1:0] pend_m = '0;
    logic     inject = 1'b0;
    logic     hs_seen = 1'b0;
    int       hs_port = -1;

    always #5 clk = ~clk;

    single_integer_part_arbiter #(.N_REQ(N), .UNIT_LATENCY(L)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_a          (req_a),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_c         (resp_c),
        .unit_in_valid  (unit_in_valid),
        .unit_a         (unit_a),
        .unit_out_valid (unit_out_valid),
        .unit_c         (unit_c),
        .err            (err)
    );

    // Truncate toward zero by clearing the fractional mantissa bits.
    function automatic logic [31:0] trunc_f(input logic [31:0] x);
        int e;
        logic [31:0] m;
        e = int'(x[30:23]);
        if (e >= 150) return x;
        if (e < 127) return {x[31], 31'b0};
        m = 32'hFFFF_FFFF << (150 - e);
        return x & m;
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] v;
        v = $urandom;
        if ($urandom_range(0, 3) != 0) v[30:23] = 8'($urandom_range(118, 155));
        return v;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Sample and model at negedge, then advance and drive the unit after posedge.
    task automatic tick();
        int g;
        int p;
        exp_t e;
        logic [31:0] exp_rdy;
        @(negedge clk);
        hs_seen = 1'b0;
        if (rst) begin
            check32("req_ready_in_rst", 32'(req_ready), 32'h0);
            pend_m = '0;
            rr_m   = 0;
            for (int q = 0; q < N; q++) sb[q].delete();
        end else begin
            g = -1;
            for (int k = 0; k < N; k++) begin
                p = (rr_m + k) % N;
                if (g < 0 && req_valid[p] && !pend_m[p]) g = p;
            end
            exp_rdy = (g >= 0) ? (32'h1 << g) : 32'h0;
            check32("req_ready", 32'(req_ready), exp_rdy);
            if (g >= 0) begin
                e.c   = trunc_f(req_a[32*g +: 32]);
                e.due = cyc + L + 2;
                sb[g].push_back(e);
                pend_m[g] = 1'b1;
                rr_m      = (g + 1) % N;
                hs_seen   = 1'b1;
                hs_port   = g;
            end
            for (int q = 0; q < N; q++)
                if (resp_valid[q] && resp_ready[q]) pend_m[q] = 1'b0;
        end
        if (unit_in_valid) begin
            e.c   = trunc_f(unit_a);
            e.due = cyc + L;
            upipe.push_back(e);
        end
        @(posedge clk);
        #1;
        cyc++;
        unit_out_valid = 1'b0;
        if (upipe.size() > 0 && upipe[0].due == cyc) begin
            e = upipe.pop_front();
            unit_out_valid = 1'b1;
            unit_c         = e.c;
        end
        if (inject) begin
            unit_out_valid = 1'b1;
            inject         = 1'b0;
`ifdef SINGLE_INT_ARB_ERR_EN
            err_set_cyc = cyc + 1;
`endif
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input int p, input logic [31:0] a);
        logic got;
        got = 1'b0;
        req_a[32*p +: 32] = a;
        req_valid[p] = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (hs_seen && hs_port == p) got = 1'b1;
        end
        check32("send_accepted", 32'(got), 32'h1);
        req_valid[p] = 1'b0;
    endtask

    // Monitor: pops the scoreboard when the DUT presents results.
    initial begin
        logic [N-1:0] prev;
        logic         exp_err;
        prev = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = '0;
            end else begin
                for (int p = 0; p < N; p++) begin
                    if (resp_valid[p] && !prev[p]) begin
                        n_cmp++;
                        if (sb[p].size() == 0) begin
                            n_fail++;
                            $display("FAIL unexpected_resp port %0d: resp_c=%h with nothing outstanding (cycle %0d)",
                                     p, resp_c[32*p +: 32], cyc);
                        end else begin
                            check32($sformatf("resp_c[%0d]", p), resp_c[32*p +: 32], sb[p][0].c);
                            check32($sformatf("resp_cycle[%0d]", p), cyc, sb[p][0].due);
                        end
                    end
                    if (resp_valid[p] && resp_ready[p] && sb[p].size() > 0) void'(sb[p].pop_front());
                end
                prev = resp_valid;
                exp_err = (err_set_cyc >= 0) && (cyc >= err_set_cyc);
                check32("err", 32'(err), 32'(exp_err));
            end
        end
    end

    initial begin
        logic busy;
        rst            = 1'b1;
        req_valid      = '0;
        req_a          = '0;
        resp_ready     = '0;
        unit_out_valid = 1'b0;
        unit_c         = '0;
        tick();
        req_valid = '1;
        tick();
        check32("rst_resp_valid", 32'(resp_valid), 32'h0);
        for (int p = 0; p < N; p++) check32("rst_resp_c", resp_c[32*p +: 32], 32'h0);
        check32("rst_unit_in_valid", 32'(unit_in_valid), 32'h0);
        check32("rst_unit_a", unit_a, 32'h0);
        check32("rst_err", 32'(err), 32'h0);
        req_valid  = '0;
        rst        = 1'b0;
        resp_ready = '1;

        send(0, 32'h4070_0000); idle(4);
        send(1, 32'hC020_0000); idle(4);
        send(2, 32'h3F00_0000); idle(4);

        for (int i = 0; i < 16; i++) begin
            for (int p = 0; p < N; p++) req_a[32*p +: 32] = rand_fp();
            req_valid = '1;
            tick();
        end

        resp_ready = 4'b1110;
        for (int i = 0; i < 12; i++) begin
            for (int p = 0; p < N; p++) req_a[32*p +: 32] = rand_fp();
            tick();
        end
        resp_ready = '1;
        idle(8);

        for (int i = 0; i < 400; i++) begin
            req_valid  = N'($urandom);
            resp_ready = N'($urandom);
            for (int p = 0; p < N; p++) req_a[32*p +: 32] = rand_fp();
            tick();
        end
        req_valid  = '0;
        resp_ready = '1;
        idle(8);

        send(3, 32'h41B8_0000);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle(6);
        send(3, 32'hC1A4_CCCD);
        idle(6);

        inject = 1'b1;
        idle(5);
        rst = 1'b1;
        err_set_cyc = -1;
        tick();
        rst = 1'b0;
        idle(3);

        busy = 1'b1;
        for (int i = 0; i < 40 && busy; i++) begin
            busy = (upipe.size() != 0);
            for (int p = 0; p < N; p++) if (sb[p].size() != 0) busy = 1'b1;
            if (busy) tick();
        end
        for (int p = 0; p < N; p++) check32($sformatf("sb_empty[%0d]", p), sb[p].size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
